wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between two requesters. The primary requester is the in-order pipeline write-back stage (the WB stage's reg_waddr/reg_wdata/reg_wen). The secondary requester is a long-latency unit (multiply/divide, late load return) behind a valid/ready handshake. Secondary results are buffered in a small FIFO. The pipeline has priority, but a starvation counter forces a FIFO drain by stalling the pipeline. The block sits between the WB stage and the regfile, and its registered outputs drive the regfile write port.

## Interface
- FIFO_DEPTH, 2: secondary-result buffer entries (power of two, ≥2).
- STARVE_MAX, 4: consecutive cycles a non-empty FIFO may be denied before a forced grant.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_waddr_i  in  5  pipeline WB destination register.
- pipe_wdata_i  in  64  pipeline WB data.
- pipe_wen_i  in  1  pipeline WB write request.
- pipe_stall_o  out  1  high means the pipeline must hold its WB inputs unchanged next cycle.
- lu_valid_i  in  1  long-latency result valid.
- lu_ready_o  out  1  arbiter can accept a result.
- lu_waddr_i  in  5  long-latency destination register.
- lu_wdata_i  in  64  long-latency data.
- reg_waddr_o  out  5  regfile write address (registered).
- reg_wdata_o  out  64  regfile write data (registered).
- reg_wen_o  out  1  regfile write enable (registered).

## Operation
- **Effective pipeline request:** pipe_req = pipe_wen_i && pipe_waddr_i != 0. Writes to x0 never use the port.
- **Enqueue:** on lu_valid_i && lu_ready_o the entry is accepted.
  - lu_waddr_i == 0: handshake completes, nothing is stored.
  - Otherwise the entry is pushed at the tail.
- **Ready:** lu_ready_o = (count < FIFO_DEPTH), using the registered count. There is no bypass: when full, lu_ready_o is low even if a pop occurs that cycle.
- **Arbitration, each cycle, evaluated on the registered FIFO state:**
  - force = fifo_nonempty && starve_cnt == STARVE_MAX.
  - pipe_req && !force: grant the pipeline.
  - Else if fifo_nonempty: grant the FIFO head and pop. pipe_stall_o = pipe_req.
  - Else: no write.
- **pipe_stall_o** is high only when pipe_req && force. It is combinational.
- **Starvation counter:**
  - Cleared when the FIFO is empty or the FIFO is granted.
  - Otherwise incremented, saturating at STARVE_MAX.
- **Same-cycle push and pop:** a simultaneous push and pop leaves count unchanged. The pointers wrap modulo FIFO_DEPTH.
- **Ordering:**
  - FIFO entries retire in acceptance order.
  - WAW/RAW ordering between the pipeline and the long-latency unit on the same register is the hazard unit's responsibility. The arbiter does not check it.

## Timing
- **Reset:** all of the following are forced while rst is low, asynchronously:
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - count=0, pointers=0, starve_cnt=0.
  - lu_ready_o=1, pipe_stall_o=0.
  - Entries in flight when reset asserts are discarded.
- **Latency:**
  - Granted request to reg_wen_o: 1 cycle (the outputs register the granted address and data at the next edge).
  - Accepted long-latency entry: earliest write is 2 cycles after acceptance (visible to arbitration the cycle after push, then 1 cycle of output register).
- **Idle:** reg_wen_o=0 in any cycle with no grant. reg_waddr_o and reg_wdata_o hold their last values.
- **Worst-case pipeline stall:** one cycle per STARVE_MAX+1 cycles while the FIFO is non-empty. A stall never lasts two consecutive cycles, because starve_cnt clears on the FIFO grant.
- **Under stall:** the pipeline re-presents the same request the next cycle, and it is granted then.

## Test plan
- **Reset:** assert rst low mid-stream with FIFO count=2 → reg_wen_o=0 and lu_ready_o=1 immediately. After release, no stale entries are written.
- **Pipeline only:** pipe_wen_i=1, waddr=5, wdata=0xDEAD for 1 cycle → next cycle reg_wen_o=1, reg_waddr_o=5, reg_wdata_o=0xDEAD. With waddr=0 → reg_wen_o stays 0.
- **Idle port:** with no pipeline traffic, push lu waddr=7, data=0x1234 at cycle t → reg_wen_o=1 with waddr 7 at t+2, and pipe_stall_o never asserts.
- **Starvation:** pipe_req continuously high with one FIFO entry pending (STARVE_MAX=4) → pipeline granted 4 cycles, then pipe_stall_o=1 for exactly 1 cycle, the FIFO entry is written, and the held pipeline request is written the following cycle.
- **Full FIFO:** fill 2 entries while the pipeline saturates the port → lu_ready_o=0. A lu_valid_i held high is accepted the cycle after the first forced pop. FIFO entries retire in push order.
- **x0 drop:** lu push with waddr=0 → handshake completes, count unchanged, no regfile write.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the WB pipeline has priority, and long-latency results queue in a FIFO.
// A starvation counter forces a FIFO drain by stalling the pipeline for one cycle.
module wb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [63:0] pipe_wdata_i,
  input  logic        pipe_wen_i,
  output logic        pipe_stall_o,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_waddr_i,
  input  logic [63:0] lu_wdata_i,
  output logic [4:0]  reg_waddr_o,
  output logic [63:0] reg_wdata_o,
  output logic        reg_wen_o
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 64;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wr_req_t;

  wr_req_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [AW-1:0]    reg_waddr_q, reg_waddr_d;
  logic [DW-1:0]    reg_wdata_q, reg_wdata_d;
  logic             reg_wen_q, reg_wen_d;

  logic    pipe_req, fifo_nonempty, force_fifo;
  logic    grant_pipe, grant_fifo, push;
  wr_req_t head;

  // Arbitration is evaluated on the registered FIFO state only.
  always_comb begin
    pipe_req      = pipe_wen_i && (pipe_waddr_i != '0);
    fifo_nonempty = (count_q != '0);
    force_fifo    = fifo_nonempty && (starve_q == STV_W'(STARVE_MAX));
    grant_pipe    = pipe_req && !force_fifo;
    grant_fifo    = !grant_pipe && fifo_nonempty;
    push          = lu_valid_i && lu_ready_o && (lu_waddr_i != '0);
    head          = mem_q[rd_ptr_q];
  end

  assign lu_ready_o   = (count_q < CNT_W'(FIFO_DEPTH));
  assign pipe_stall_o = pipe_req && force_fifo;

  // Next-state for FIFO bookkeeping, starvation counter and output register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    starve_d    = starve_q;
    reg_wen_d   = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (grant_fifo) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, grant_fifo})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (!fifo_nonempty || grant_fifo) begin
      starve_d = '0;
    end else if (starve_q != STV_W'(STARVE_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end

    if (grant_pipe) begin
      reg_wen_d   = 1'b1;
      reg_waddr_d = pipe_waddr_i;
      reg_wdata_d = pipe_wdata_i;
    end else if (grant_fifo) begin
      reg_wen_d   = 1'b1;
      reg_waddr_d = head.waddr;
      reg_wdata_d = head.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      reg_wen_q   <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      reg_wen_q   <= reg_wen_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{waddr: lu_waddr_i, wdata: lu_wdata_i};
    end
  end

  assign reg_wen_o   = reg_wen_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: per-source in-order queues plus latency/stall timing checks.
// Long-latency results use waddr 7 or >=16; pipeline writes use 5 and 8..15.
module tb_wb_port_arbiter;

  typedef logic [68:0] exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  pipe_waddr;
  logic [63:0] pipe_wdata;
  logic        pipe_wen;
  logic        pipe_stall_o;
  logic        lu_valid;
  logic        lu_ready_o;
  logic [4:0]  lu_waddr;
  logic [63:0] lu_wdata;
  logic [4:0]  reg_waddr_o;
  logic [63:0] reg_wdata_o;
  logic        reg_wen_o;

  exp_t pipe_q[$];
  exp_t lu_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int stall_cnt = 0;
  int consec_cnt = 0;
  int lu_last_pos = 0;
  logic stall_prev = 1'b0;
  int base, s0, w, w2;

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_waddr_i (pipe_waddr),
    .pipe_wdata_i (pipe_wdata),
    .pipe_wen_i   (pipe_wen),
    .pipe_stall_o (pipe_stall_o),
    .lu_valid_i   (lu_valid),
    .lu_ready_o   (lu_ready_o),
    .lu_waddr_i   (lu_waddr),
    .lu_wdata_i   (lu_wdata),
    .reg_waddr_o  (reg_waddr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_wen_o    (reg_wen_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_lu(input logic [4:0] a);
    return (a == 5'd7) || (a >= 5'd16);
  endfunction

  // Drive one pipeline request, holding it while the arbiter stalls the pipeline.
  task automatic pipe_issue(input logic [4:0] a, input logic [63:0] d);
    int n;
    n = 0;
    pipe_wen   = 1'b1;
    pipe_waddr = a;
    pipe_wdata = d;
    if (a != 5'd0) pipe_q.push_back({a, d});
    @(negedge clk);
    while (pipe_stall_o && n < 4) begin
      n++;
      @(negedge clk);
    end
    if (n > 1) chk("stall_len", 64'(n), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Present a long-latency result until the handshake completes; returns cycles spent not ready.
  task automatic lu_push(input logic [4:0] a, input logic [63:0] d, output int waited);
    waited   = 0;
    lu_valid = 1'b1;
    lu_waddr = a;
    lu_wdata = d;
    @(negedge clk);
    while (!lu_ready_o && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!lu_ready_o) chk("lu_accept", 64'(lu_ready_o), 64'd1);
    else if (a != 5'd0) lu_q.push_back({a, d});
    @(posedge clk);
    #1;
    lu_valid = 1'b0;
  endtask

  // Monitor: every regfile write must match the head of its source's scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pipe_stall_o) begin
          stall_cnt++;
          if (stall_prev) consec_cnt++;
        end
        stall_prev = pipe_stall_o;
        if (reg_wen_o) begin
          if (is_lu(reg_waddr_o)) begin
            lu_last_pos = wr_cnt;
            chk("lu_sb_pending", 64'(lu_q.size() != 0), 64'd1);
            if (lu_q.size() != 0) begin
              mon_e = lu_q.pop_front();
              chk("lu_waddr", 64'(reg_waddr_o), 64'(mon_e[68:64]));
              chk("lu_wdata", reg_wdata_o, mon_e[63:0]);
            end
          end else begin
            chk("pipe_sb_pending", 64'(pipe_q.size() != 0), 64'd1);
            if (pipe_q.size() != 0) begin
              mon_e = pipe_q.pop_front();
              chk("pipe_waddr", 64'(reg_waddr_o), 64'(mon_e[68:64]));
              chk("pipe_wdata", reg_wdata_o, mon_e[63:0]);
            end
          end
          wr_cnt++;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
    #2;
    chk("rst_wen",   64'(reg_wen_o),    64'd0);
    chk("rst_ready", 64'(lu_ready_o),   64'd1);
    chk("rst_stall", 64'(pipe_stall_o), 64'd0);
    chk("rst_waddr", 64'(reg_waddr_o),  64'd0);
    chk("rst_wdata", reg_wdata_o,       64'd0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    // Pipeline only, then an x0 pipeline request that must not use the port.
    pipe_issue(5'd5, 64'hDEAD);
    chk("pipe_lat_wen",   64'(reg_wen_o),   64'd1);
    chk("pipe_lat_waddr", 64'(reg_waddr_o), 64'd5);
    chk("pipe_lat_wdata", reg_wdata_o,      64'hDEAD);
    pipe_issue(5'd0, 64'hBEEF);
    pipe_wen = 1'b0;
    chk("pipe_x0_wen",   64'(reg_wen_o),   64'd0);
    chk("idle_hold_addr", 64'(reg_waddr_o), 64'd5);
    chk("idle_hold_data", reg_wdata_o,      64'hDEAD);

    // Idle port: long-latency write appears two cycles after acceptance.
    s0 = stall_cnt;
    lu_push(5'd7, 64'h1234, w);
    chk("lu_lat1_wen", 64'(reg_wen_o), 64'd0);
    @(posedge clk); #1;
    chk("lu_lat2_wen",   64'(reg_wen_o),   64'd1);
    chk("lu_lat2_waddr", 64'(reg_waddr_o), 64'd7);
    chk("lu_lat2_wdata", reg_wdata_o,      64'h1234);
    @(posedge clk); #1;
    chk("lu_idle_after", 64'(reg_wen_o), 64'd0);
    chk("idle_no_stall", 64'(stall_cnt - s0), 64'd0);

    // Starvation: one pending entry against a saturated pipeline.
    base = wr_cnt; s0 = stall_cnt;
    fork
      lu_push(5'd20, 64'hA5A5, w);
      for (int i = 0; i < 8; i++) pipe_issue(5'(8 + i % 8), 64'h100 + 64'(i));
    join
    pipe_wen = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("starve_stalls", 64'(stall_cnt - s0), 64'd1);
    chk("starve_lu_pos", 64'(lu_last_pos - base), 64'd5);
    chk("starve_total",  64'(wr_cnt - base), 64'd9);

    // Full FIFO: third result waits until the cycle after the first forced pop.
    base = wr_cnt;
    fork
      begin
        lu_push(5'd17, 64'h1717, w);
        lu_push(5'd18, 64'h1818, w);
        lu_push(5'd19, 64'h1919, w2);
      end
      for (int i = 0; i < 16; i++) pipe_issue(5'(8 + i % 8), 64'h200 + 64'(i));
    join
    pipe_wen = 1'b0;
    chk("full_wait", 64'(w2), 64'd4);
    repeat (8) @(posedge clk);
    #1;
    chk("full_total", 64'(wr_cnt - base), 64'd19);
    chk("full_ready_after", 64'(lu_ready_o), 64'd1);

    // x0 drop: handshake completes without occupying a FIFO slot.
    base = wr_cnt;
    fork
      begin
        lu_push(5'd21, 64'h2121, w);
        lu_push(5'd0, 64'hBAD, w);
        @(negedge clk);
        chk("x0_ready", 64'(lu_ready_o), 64'd1);
      end
      for (int i = 0; i < 6; i++) pipe_issue(5'(8 + i % 8), 64'h300 + 64'(i));
    join
    pipe_wen = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("x0_total", 64'(wr_cnt - base), 64'd7);

    // Reset mid-stream with two entries buffered.
    fork
      begin
        lu_push(5'd22, 64'h2222, w);
        lu_push(5'd23, 64'h2323, w);
      end
      for (int i = 0; i < 3; i++) pipe_issue(5'(8 + i), 64'h400 + 64'(i));
    join
    pipe_wen = 1'b0;
    chk("pre_rst_full", 64'(lu_ready_o), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_wen",   64'(reg_wen_o),    64'd0);
    chk("mid_rst_ready", 64'(lu_ready_o),   64'd1);
    chk("mid_rst_stall", 64'(pipe_stall_o), 64'd0);
    chk("mid_rst_waddr", 64'(reg_waddr_o),  64'd0);
    lu_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    base = wr_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_stale", 64'(wr_cnt - base), 64'd0);
    chk("rst_ready_after", 64'(lu_ready_o), 64'd1);

    chk("no_consec_stall", 64'(consec_cnt), 64'd0);
    chk("pipe_sb_drained", 64'(pipe_q.size()), 64'd0);
    chk("lu_sb_drained",   64'(lu_q.size()),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
